// File: rtl/cfs_md_pkg.sv
// Shared types and width helpers for the MD TX controller.
// Width helpers evaluate at elaboration; legal() runs on every popped entry.
package cfs_md_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } tx_state_e;

  function automatic int off_w(input int bytes);
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

  function automatic int size_w(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

  function automatic int entry_w(input int data_width);
    return data_width + off_w(data_width / 8) + size_w(data_width / 8);
  endfunction

  // 32-bit operands keep offset+size from wrapping for any legal width.
  function automatic logic legal(input int unsigned offset,
                                 input int unsigned size,
                                 input int unsigned bytes);
    return (size != 0) && ((offset + size) <= bytes);
  endfunction

endpackage

// File: rtl/cfs_md_tx_ctrl_if.sv
// MD TX valid/ready bus between the controller (master) and the MD slave.
interface cfs_md_tx_ctrl_if
  import cfs_md_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFFSET_W = off_w(BYTES);
  localparam int SIZE_W   = size_w(BYTES);

  logic                  md_tx_valid;
  logic [DATA_WIDTH-1:0] md_tx_data;
  logic [OFFSET_W-1:0]   md_tx_offset;
  logic [SIZE_W-1:0]     md_tx_size;
  logic                  md_tx_ready;
  logic                  md_tx_err;

  modport master (
    output md_tx_valid, md_tx_data, md_tx_offset, md_tx_size,
    input  md_tx_ready, md_tx_err
  );

  modport slave (
    input  md_tx_valid, md_tx_data, md_tx_offset, md_tx_size,
    output md_tx_ready, md_tx_err
  );

endinterface

// File: rtl/cfs_sat_cnt.sv
// 8-bit saturating event counter; a clear wins over a same-cycle increment.
module cfs_sat_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [7:0] o_cnt
);

  logic [7:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cfs_md_tx_ctrl.sv
// Pops {size, offset, data} entries from the sync FIFO and presents them on the MD TX bus,
// dropping illegal entries and tracking drops, slave errors and long stalls.
module cfs_md_tx_ctrl
  import cfs_md_pkg::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter int  STALL_LIMIT = 64,
  localparam int BYTES       = DATA_WIDTH / 8,
  localparam int OFFSET_W    = off_w(BYTES),
  localparam int SIZE_W      = size_w(BYTES),
  localparam int ENTRY_W     = entry_w(DATA_WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pop_valid,
  input  logic [ENTRY_W-1:0] pop_data,
  output logic               pop_ready,
  cfs_md_tx_ctrl_if.master   md,
  input  logic               cnt_clr,
  output logic [7:0]         drop_cnt,
  output logic [7:0]         err_cnt,
  output logic               stall_flag,
  output logic               busy
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  logic [DATA_WIDTH-1:0] w_data;
  logic [OFFSET_W-1:0]   w_offset;
  logic [SIZE_W-1:0]     w_size;
  logic                  w_idle;
  logic                  w_hs;
  logic                  w_pop;
  logic                  w_legal;
  logic                  w_take;
  logic                  w_drop;
  logic                  w_err_inc;

  tx_state_e             r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [OFFSET_W-1:0]   r_offset;
  logic [SIZE_W-1:0]     r_size;
  logic [STALL_W-1:0]    r_stall_cnt;
  logic                  r_stall_flag;

  assign {w_size, w_offset, w_data} = pop_data;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_hs      = !w_idle && md.md_tx_ready;
  assign pop_ready = enable && (w_idle || md.md_tx_ready);
  assign w_pop     = pop_valid && pop_ready;
  assign w_legal   = legal(32'(w_offset), 32'(w_size), 32'(BYTES));
  assign w_take    = w_pop && w_legal;
  assign w_drop    = w_pop && !w_legal;
  assign w_err_inc = w_hs && md.md_tx_err;

  // Payload only loads on a legal pop, so illegal entries never reach the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_offset <= '0;
      r_size   <= '0;
    end else begin
      if (w_take) begin
        r_data   <= w_data;
        r_offset <= w_offset;
        r_size   <= w_size;
      end
      case (r_state)
        ST_IDLE:  if (w_take) r_state <= ST_DRIVE;
        ST_DRIVE: if (w_hs && !w_take) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // The flag sets one edge after the counter saturates and stays until cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_stall_flag <= 1'b0;
    end else begin
      if (!w_idle && !md.md_tx_ready) begin
        if (r_stall_cnt != STALL_W'(STALL_LIMIT)) begin
          r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
      end else begin
        r_stall_cnt <= '0;
      end
      if (cnt_clr) begin
        r_stall_flag <= 1'b0;
      end else if (r_stall_cnt == STALL_W'(STALL_LIMIT)) begin
        r_stall_flag <= 1'b1;
      end
    end
  end

  cfs_sat_cnt u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_drop),
    .i_clr (cnt_clr),
    .o_cnt (drop_cnt)
  );

  cfs_sat_cnt u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_err_inc),
    .i_clr (cnt_clr),
    .o_cnt (err_cnt)
  );

  assign md.md_tx_valid  = !w_idle;
  assign md.md_tx_data   = r_data;
  assign md.md_tx_offset = r_offset;
  assign md.md_tx_size   = r_size;
  assign stall_flag      = r_stall_flag;
  assign busy            = !w_idle || w_pop;

endmodule

// File: tb/tb_cfs_md_tx_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_cfs_md_tx_ctrl;
  import cfs_md_pkg::*;

  localparam int DW    = 32;
  localparam int LIMIT = 64;
  localparam int BYTES = DW / 8;
  localparam int EW    = entry_w(DW);

  typedef struct {
    int unsigned size;
    int unsigned off;
    logic [31:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          pop_valid;
  logic [EW-1:0] pop_data;
  logic          pop_ready;
  logic          cnt_clr;
  logic [7:0]    drop_cnt;
  logic [7:0]    err_cnt;
  logic          stall_flag;
  logic          busy;

  cfs_md_tx_ctrl_if #(.DATA_WIDTH(DW)) md ();

  cfs_md_tx_ctrl #(.DATA_WIDTH(DW), .STALL_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .pop_ready  (pop_ready),
    .md         (md),
    .cnt_clr    (cnt_clr),
    .drop_cnt   (drop_cnt),
    .err_cnt    (err_cnt),
    .stall_flag (stall_flag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: source FIFO contents, the held transfer, counters and stall run length.
  entry_t src_q[$];
  bit     m_have;
  entry_t m_cur;
  int     m_drop;
  int     m_err;
  int     m_run;
  bit     m_flag;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input entry_t e);
    logic [2:0] s;
    logic [1:0] o;
    s = e.size[2:0];
    o = e.off[1:0];
    return {s, o, e.data};
  endfunction

  function automatic bit model_legal(input entry_t e);
    return (e.size != 0) && (e.off + e.size <= BYTES);
  endfunction

  function automatic entry_t mk(input int unsigned size, input int unsigned off,
                                input logic [31:0] data);
    entry_t e;
    e.size = size;
    e.off  = off;
    e.data = data;
    return e;
  endfunction

  // One clock cycle: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(input bit en, input bit rdy, input bit err, input bit clr);
    bit     exp_pr;
    bit     consumed;
    bit     hs;
    entry_t e;
    enable         = en;
    md.md_tx_ready = rdy;
    md.md_tx_err   = err;
    cnt_clr        = clr;
    pop_valid      = (src_q.size() > 0);
    pop_data       = pop_valid ? pack(src_q[0]) : '0;
    @(negedge clk);
    exp_pr   = en && (!m_have || rdy);
    consumed = pop_valid && exp_pr;
    hs       = m_have && rdy;
    check("md_tx_valid", md.md_tx_valid, m_have);
    if (m_have) begin
      check("md_tx_data", md.md_tx_data, m_cur.data);
      check("md_tx_offset", md.md_tx_offset, m_cur.off);
      check("md_tx_size", md.md_tx_size, m_cur.size);
    end
    check("pop_ready", pop_ready, exp_pr);
    check("busy", busy, m_have || consumed);
    check("drop_cnt", drop_cnt, m_drop);
    check("err_cnt", err_cnt, m_err);
    check("stall_flag", stall_flag, m_flag);
    @(posedge clk);
    if (clr) m_flag = 0;
    else if (m_run >= LIMIT) m_flag = 1;
    m_run = (m_have && !rdy) ? m_run + 1 : 0;
    if (clr) begin
      m_drop = 0;
      m_err  = 0;
    end else begin
      if (consumed && !model_legal(src_q[0]) && m_drop < 255) m_drop++;
      if (hs && err && m_err < 255) m_err++;
    end
    if (consumed) begin
      e = src_q.pop_front();
      if (model_legal(e)) begin
        m_have = 1;
        m_cur  = e;
      end else if (hs) begin
        m_have = 0;
      end
    end else if (hs) begin
      m_have = 0;
    end
    #1;
  endtask

  // Asserts reset mid-cycle (asynchronously) and checks the reset state immediately.
  task automatic apply_reset();
    #2;
    reset          = 1'b1;
    enable         = 1'b0;
    pop_valid      = 1'b0;
    pop_data       = '0;
    md.md_tx_ready = 1'b0;
    md.md_tx_err   = 1'b0;
    cnt_clr        = 1'b0;
    #1;
    check("rst_md_tx_valid", md.md_tx_valid, 0);
    check("rst_md_tx_data", md.md_tx_data, 0);
    check("rst_md_tx_offset", md.md_tx_offset, 0);
    check("rst_md_tx_size", md.md_tx_size, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_stall_flag", stall_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_pop_ready", pop_ready, 0);
    src_q.delete();
    m_have = 0;
    m_drop = 0;
    m_err  = 0;
    m_run  = 0;
    m_flag = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply_reset();

    // Single transfer accepted in its first valid cycle.
    src_q.push_back(mk(4, 0, 32'hDEADBEEF));
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Back-to-back legal entries with the slave always ready.
    for (int i = 0; i < 4; i++) src_q.push_back(mk(1 + i, 0, 32'h1111_0000 + i));
    repeat (6) step(1, 1, 0, 0);

    // Two illegal entries followed by a legal one at the upper boundary.
    src_q.push_back(mk(0, 0, 32'hAAAA_0000));
    src_q.push_back(mk(3, 2, 32'hBBBB_0000));
    src_q.push_back(mk(2, 2, 32'hCCCC_0000));
    repeat (5) step(1, 1, 0, 0);
    check("drops_after_illegal", drop_cnt, 8'd2);

    // Long backpressure: stall flag sets, outputs hold, next entry waits.
    src_q.push_back(mk(4, 0, 32'h5A5A_A5A5));
    src_q.push_back(mk(1, 3, 32'h0000_00EE));
    step(1, 1, 0, 0);
    repeat (70) step(1, 0, 0, 0);
    check("stall_flag_set", stall_flag, 1'b1);
    step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);
    check("stall_flag_cleared", stall_flag, 1'b0);

    // Randomized traffic, including illegal entries, errors and occasional clears.
    repeat (3000) begin
      if ($urandom_range(0, 2) == 0 && src_q.size() < 8) begin
        if ($urandom_range(0, 4) == 0)
          src_q.push_back(mk($urandom_range(0, 7), $urandom_range(0, 3), $urandom));
        else
          src_q.push_back(mk($urandom_range(1, 4), $urandom_range(0, 3), $urandom));
      end
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    while (src_q.size() > 0 || m_have) step(1, 1, 0, 0);
    step(1, 0, 0, 1);

    // Error counter saturation, then a clear coincident with an error handshake.
    repeat (300) begin
      src_q.push_back(mk(4, 0, $urandom));
      step(1, 1, 1, 0);
    end
    check("err_cnt_saturated", err_cnt, 8'd255);
    step(1, 1, 1, 0);
    src_q.push_back(mk(2, 1, 32'h1234_5678));
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    check("err_cnt_clr_wins", err_cnt, 8'd0);

    // Enable drops while driving: current transfer completes, no further pops.
    src_q.push_back(mk(4, 0, 32'hE0E0_0001));
    src_q.push_back(mk(5, 0, 32'hE0E0_0002));
    src_q.push_back(mk(2, 0, 32'hE0E0_0003));
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("drop_before_reset", drop_cnt, 8'd1);

    // Asynchronous reset while a transfer is held, then normal operation resumes.
    apply_reset();
    src_q.push_back(mk(3, 1, 32'h0BAD_F00D));
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cfs_md_tx_ctrl.md
Name: cfs_md_tx_ctrl

Overview:
- Downstream consumer of the synchronisation FIFO pop side; runs in the FIFO pop clock domain.
- Pops packed {size, offset, data} entries and drives them onto the MD TX valid/ready interface.
- Holds each transfer stable until the MD slave accepts it.
- Drops illegal entries, counts drops and slave errors, and flags long stalls for the APB register block.

Parameters:
- DATA_WIDTH, 32, MD data bus width in bits; multiple of 8, at least 8.
- STALL_LIMIT, 64, consecutive cycles of md_tx_valid=1 with md_tx_ready=0 before stall_flag sets; at least 1.
- Derived constants: BYTES=DATA_WIDTH/8, OFFSET_W=max(1,$clog2(BYTES)), SIZE_W=$clog2(BYTES)+1, ENTRY_W=DATA_WIDTH+OFFSET_W+SIZE_W.

Ports:
- clk  in  1  clock, shared with FIFO pop_clk
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = pop new entries; 0 = finish the current transfer, then idle
- pop_valid  in  1  FIFO has an entry
- pop_data  in  ENTRY_W  {size, offset, data}; data in LSBs
- pop_ready  out  1  entry consumed this cycle when high together with pop_valid
- md_tx_valid  out  1  MD transfer valid
- md_tx_data  out  DATA_WIDTH  MD data
- md_tx_offset  out  OFFSET_W  byte offset
- md_tx_size  out  SIZE_W  byte count
- md_tx_ready  in  1  MD slave accepts the transfer
- md_tx_err  in  1  slave error, sampled only in the handshake cycle
- cnt_clr  in  1  synchronous clear of both counters and stall_flag
- drop_cnt  out  8  saturating count of illegal entries dropped
- err_cnt  out  8  saturating count of accepted transfers with md_tx_err=1
- stall_flag  out  1  sticky, set when stall counter reaches STALL_LIMIT
- busy  out  1  md_tx_valid OR an entry being consumed this cycle

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; stall counter 0.
- FSM has two states:
  - IDLE: md_tx_valid=0.
  - DRIVE: md_tx_valid=1; md_tx_data, md_tx_offset and md_tx_size are frozen.
- pop_ready = enable AND (state==IDLE OR md_tx_ready), combinational.
- Legality check on a popped entry: legal iff size!=0 AND offset+size<=BYTES. The sum is evaluated at SIZE_W+1 bits so it cannot wrap.
- Legal pop: output registers load the entry at the next edge; state becomes DRIVE. Latency from pop to md_tx_valid is 1 cycle.
- Illegal pop:
  - Entry consumed and discarded; drop_cnt increments.
  - If the cycle also completes a handshake, state goes to IDLE; otherwise state is unchanged.
  - The MD outputs never show an illegal entry.
- DRIVE with md_tx_ready=1:
  - Handshake completes.
  - If a legal entry is popped in the same cycle, stay in DRIVE with the new entry. This gives back-to-back transfers at 1/cycle.
  - Otherwise go to IDLE.
- md_tx_data/offset/size keep their last value in IDLE; they are don't-care for the slave.
- md_tx_err is sampled only when md_tx_valid AND md_tx_ready. It increments err_cnt and does not stall the FSM.
- Counters:
  - 8-bit, saturate at 255.
  - cnt_clr has priority over a same-cycle increment; that increment is lost.
- Stall counter:
  - Increments each cycle while valid=1 and ready=0; resets to 0 on handshake or when in IDLE.
  - Saturates at STALL_LIMIT. On reaching it, stall_flag is set at the next edge.
  - stall_flag stays set until cnt_clr or reset.
- enable deassertion: no new pops from the next cycle. A transfer in DRIVE still completes normally.
- Reset mid-transfer: md_tx_valid drops asynchronously; the entry is lost. The FIFO is reset by the same source.
- pop_valid=0 in IDLE: remain in IDLE; pop_ready may be 1, which is harmless.

Decomposition:
- Shared package cfs_md_pkg holds:
  - the FSM state enum (IDLE, DRIVE);
  - functions for the derived widths (OFFSET_W, SIZE_W, ENTRY_W);
  - the legality function legal(offset, size, BYTES).
- One natural sub-module: cfs_sat_cnt, an 8-bit saturating counter with inc and clr (clr priority). It is instantiated twice, for drop_cnt and err_cnt.

Test Plan:
- Single transfer: enable=1, pop entry {size=4, offset=0, data=0xDEADBEEF}, md_tx_ready=1 one cycle after valid rises -> md_tx_valid high exactly 1 cycle with data 0xDEADBEEF/off 0/size 4; drop_cnt=0.
- Back-to-back: 4 legal entries in the FIFO, md_tx_ready tied to 1 -> 4 consecutive valid cycles, pop_ready high 4 consecutive cycles, data order preserved.
- Illegal drops: entries {size=0, off=0}, {size=3, off=2}, then {size=2, off=2} -> first two dropped, drop_cnt=2, only the third appears on MD.
- Backpressure and stall: md_tx_ready=0 for 70 cycles with STALL_LIMIT=64 -> outputs stable throughout, stall_flag set after cycle 64, pop_ready=0; then ready=1 -> handshake, stall_flag stays 1 until cnt_clr.
- Errors and saturation: 300 accepted transfers with md_tx_err=1 -> err_cnt=255; cnt_clr coincident with an error handshake -> err_cnt=0.
- Enable and reset: enable->0 while in DRIVE -> current transfer completes, then no pops despite pop_valid=1. Reset asserted in DRIVE -> md_tx_valid=0 immediately; all counters 0.
